cart_mem_arbiter: RTL
=====================

Name: cart_mem_arbiter

Overview:
- Shares the single SDRAM port between two requesters:
  - the cartridge bank controller (CPU cartridge bus, level-style rd/wr on translated 26-bit addresses);
  - the cartridge loader/save-backup engine (req/ack handshake).
- Turns level-style bus accesses into one SDRAM transaction per distinct access, stalls the CPU while it is outstanding, and guarantees loader progress with a starvation limit.
- Sits between the bank controller/loader and the SDRAM controller.

Parameters:
- ADDR_W, 26, SDRAM byte-address width.
- STARVE_MAX, 8, consecutive bank-controller grants allowed while the loader is pending before the loader is forced through.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mbc_addr  in  ADDR_W  translated cartridge address
- mbc_rd  in  1  read level
- mbc_wr  in  1  write level
- mbc_wdata  in  8  write data
- mbc_rdata  out  8  registered read data
- mbc_busy  out  1  CPU stall: access not yet complete
- ld_req  in  1  loader request, held until ld_ack
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  8  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_rdata  out  8  loader read data, valid with ld_ack
- sd_req  out  1  SDRAM request
- sd_we  out  1  SDRAM write enable
- sd_addr  out  ADDR_W  SDRAM address
- sd_wdata  out  8  SDRAM write data
- sd_ack  in  1  one-cycle completion pulse; read data valid in the same cycle
- sd_rdata  in  8  SDRAM read data

Behaviour:
- Reset values:
  - sd_req/sd_we/ld_ack/mbc_busy = 0.
  - sd_addr/sd_wdata/ld_rdata = 0.
  - mbc_rdata = 8'hFF.
  - State = IDLE, starvation counter = 0, last-access key invalid.
- Reset mid-transaction:
  - Abandons the transaction and takes no completion action.
  - The SDRAM controller is reset by the same signal.
- Bank-controller new-access detection:
  - Key = {mbc_addr, mbc_wr}.
  - Pending when (mbc_rd | mbc_wr) and (key invalid, or key ≠ last serviced key).
  - A held access with an unchanged key is never re-issued; mbc_rdata keeps its value.
  - When mbc_rd = mbc_wr = 0 for a cycle, the key becomes invalid, so the same address can be re-accessed.
  - If mbc_rd and mbc_wr are both set, treat the access as a write.
- mbc_busy is combinational: high whenever an MBC access is pending or in flight, low in the cycle mbc_rdata updates.
- FSM:
  - IDLE:
    - Arbitrates between MBC-pending and ld_req.
    - MBC wins ties unless counter == STARVE_MAX.
    - Latches sd_addr/sd_we/sd_wdata and owner; sets sd_req next cycle → REQ.
  - REQ:
    - sd_req high; addr/we/wdata stable.
    - On sd_ack: sd_req low next cycle; capture sd_rdata to the owner's read register.
      - Owner MBC: record key as last serviced.
      - Owner loader: pulse ld_ack next cycle.
    - → IDLE.
  - No timeout: REQ holds indefinitely until sd_ack.
- Latency:
  - Request visible at cycle 0 → sd_req at cycle 1.
  - sd_ack at cycle N (N ≥ 2) → mbc_rdata/ld_rdata/ld_ack at N+1.
  - Minimum one IDLE cycle between transactions.
- Starvation counter:
  - Increments on each MBC grant while ld_req is high, saturating at STARVE_MAX.
  - Clears on a loader grant, or when ld_req is low at arbitration.
- Changes to requester inputs during REQ are ignored; they are re-evaluated in IDLE.
- MBC write: mbc_rdata unchanged. Loader write: ld_rdata unchanged.
- sd_ack outside REQ is ignored.

Decomposition:
- cart_mem_pkg:
  - arb_state_t enum {IDLE, REQ}
  - owner_t enum {OWN_MBC, OWN_LD}
  - ADDR_W default
  - SDRAM_RAM_BASE = 26'h2000000
- Sub-module cart_access_detect: key register plus new-access/pending logic for the MBC side.

Test Plan:
- MBC read, mbc_addr = 0x0004150 held for 20 cycles, sd_ack 3 cycles after sd_req with sd_rdata = 0x3C:
  - exactly one sd_req, sd_we = 0;
  - mbc_rdata = 0x3C, mbc_busy falls the cycle after ack;
  - no reissue while held.
- MBC write 0x2000010 = 0xA5, then the same address held, then rd/wr dropped one cycle and rewritten:
  - two SDRAM writes total, sd_wdata = 0xA5, sd_we = 1.
- Simultaneous MBC read and ld_req write to 0x0000000:
  - MBC granted first, loader second;
  - ld_ack is a single one-cycle pulse.
- Starvation: ld_req held while MBC issues 12 distinct reads:
  - loader granted after the 8th MBC grant;
  - counter then clears.
- Reset asserted in REQ before sd_ack:
  - next cycle all outputs at reset values, mbc_rdata = 0xFF;
  - a late sd_ack is ignored.
- ld_req read from 0x0123456, sd_rdata = 0x7E:
  - sd_addr = 0x0123456;
  - ld_rdata = 0x7E with ld_ack at N+1.

Source files
------------

// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
// Imported by the arbiter top and its access-detect helper.
package cart_mem_pkg;

  localparam int ADDR_W_DEF     = 26;
  localparam int STARVE_MAX_DEF = 8;

  // First byte of cartridge RAM inside the SDRAM map.
  localparam logic [25:0] SDRAM_RAM_BASE = 26'h2000000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_MBC = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

endpackage

// File: rtl/cart_access_detect.sv
// Turns the bank controller's level-style rd/wr into "new access" events.
// Ports: i_addr/i_rd/i_wr bus levels, i_grant (key latched at grant),
//        i_done (granted key becomes last serviced), o_pending (needs issue).
module cart_access_detect
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic              i_grant,
  input  logic              i_done,
  output logic              o_pending
);

  logic [ADDR_W:0] w_key;
  logic [ADDR_W:0] r_gnt_key;
  logic [ADDR_W:0] r_last_key;
  logic            r_last_vld;
  logic            w_active;

  assign w_active = i_rd | i_wr;
  assign w_key    = {i_addr, i_wr};

  assign o_pending = w_active &
                     (~r_last_vld | (w_key != r_last_key));

  // The key recorded at completion is the one captured at grant, so bus
  // changes while the transaction is in flight are re-evaluated in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_key  <= '0;
      r_last_key <= '0;
      r_last_vld <= 1'b0;
    end else begin
      if (i_grant)
        r_gnt_key <= w_key;
      // A bus-idle cycle forgets the key so the same address can repeat.
      if (!w_active) begin
        r_last_vld <= 1'b0;
      end else if (i_done) begin
        r_last_vld <= 1'b1;
        r_last_key <= r_gnt_key;
      end
    end
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares one SDRAM port between the cartridge bank controller (level bus,
// stalled via mbc_busy) and the loader (req/ack), with a starvation limit.
// Ports: mbc_* bank-controller bus, ld_* loader handshake, sd_* SDRAM side.
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mbc_addr,
  input  logic              mbc_rd,
  input  logic              mbc_wr,
  input  logic [7:0]        mbc_wdata,
  output logic [7:0]        mbc_rdata,
  output logic              mbc_busy,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  output logic [7:0]        ld_rdata,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_wdata,
  input  logic              sd_ack,
  input  logic [7:0]        sd_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

  arb_state_t        r_state;
  arb_state_t        w_next;
  owner_t            r_owner;
  logic              r_sd_req;
  logic              r_sd_we;
  logic [ADDR_W-1:0] r_sd_addr;
  logic [7:0]        r_sd_wdata;
  logic [7:0]        r_mbc_rdata;
  logic [7:0]        r_ld_rdata;
  logic              r_ld_ack;
  logic [CW-1:0]     r_starve;

  logic w_mbc_pend;
  logic w_starved;
  logic w_gnt_mbc;
  logic w_gnt_ld;
  logic w_done;
  logic w_mbc_done;
  logic w_mbc_fly;

  cart_access_detect #(
    .ADDR_W (ADDR_W)
  ) u_detect (
    .clk       (clk),
    .reset     (reset),
    .i_addr    (mbc_addr),
    .i_rd      (mbc_rd),
    .i_wr      (mbc_wr),
    .i_grant   (w_gnt_mbc),
    .i_done    (w_mbc_done),
    .o_pending (w_mbc_pend)
  );

  assign w_starved  = (r_starve == C_MAX);
  assign w_mbc_done = w_done & (r_owner == OWN_MBC);
  assign w_mbc_fly  = (r_state == REQ) & (r_owner == OWN_MBC);

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Bank controller wins ties unless the loader has waited too long.
  always_comb begin
    w_next    = r_state;
    w_gnt_mbc = 1'b0;
    w_gnt_ld  = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_gnt_mbc = w_mbc_pend & ~(ld_req & w_starved);
        w_gnt_ld  = ld_req & ~w_gnt_mbc;
        if (w_gnt_mbc | w_gnt_ld)
          w_next = REQ;
      end
      REQ: begin
        if (sd_ack) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_MBC;
      r_sd_req    <= 1'b0;
      r_sd_we     <= 1'b0;
      r_sd_addr   <= '0;
      r_sd_wdata  <= '0;
      r_mbc_rdata <= 8'hFF;
      r_ld_rdata  <= '0;
      r_ld_ack    <= 1'b0;
      r_starve    <= '0;
    end else begin
      r_ld_ack <= 1'b0;
      if (w_gnt_mbc) begin
        r_owner    <= OWN_MBC;
        r_sd_req   <= 1'b1;
        r_sd_we    <= mbc_wr;
        r_sd_addr  <= mbc_addr;
        r_sd_wdata <= mbc_wdata;
        if (!ld_req)
          r_starve <= '0;
        else if (!w_starved)
          r_starve <= r_starve + CW'(1);
      end else if (w_gnt_ld) begin
        r_owner    <= OWN_LD;
        r_sd_req   <= 1'b1;
        r_sd_we    <= ld_we;
        r_sd_addr  <= ld_addr;
        r_sd_wdata <= ld_wdata;
        r_starve   <= '0;
      end else if (r_state == IDLE && !ld_req) begin
        r_starve <= '0;
      end
      if (w_done) begin
        r_sd_req <= 1'b0;
        if (r_owner == OWN_MBC) begin
          if (!r_sd_we)
            r_mbc_rdata <= sd_rdata;
        end else begin
          if (!r_sd_we)
            r_ld_rdata <= sd_rdata;
          r_ld_ack <= 1'b1;
        end
      end
    end
  end

  assign mbc_busy  = w_mbc_pend | w_mbc_fly;
  assign mbc_rdata = r_mbc_rdata;
  assign ld_ack    = r_ld_ack;
  assign ld_rdata  = r_ld_rdata;
  assign sd_req    = r_sd_req;
  assign sd_we     = r_sd_we;
  assign sd_addr   = r_sd_addr;
  assign sd_wdata  = r_sd_wdata;

endmodule
